palette_lut: RTL and testbench

PALETTE_LUT -- requirements
Module: palette_lut

---
 rtl/palette_lut_if.sv | 21 ++
 rtl/palette_lut.sv | 118 +++++++++++
 tb/tb_palette_lut.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/palette_lut_if.sv
// Avalon-MM slave bus for the palette lookup table (entry space + control space).
interface palette_lut_if #(parameter int AW = 6);
  logic          AVL_CS;
  logic          AVL_READ;
  logic          AVL_WRITE;
  logic [AW-1:0] AVL_ADDR;
  logic [31:0]   AVL_WRITEDATA;
  logic [3:0]    AVL_BYTE_EN;
  logic [31:0]   AVL_READDATA;
  logic          AVL_READDATAVALID;

  modport master (
    output AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_WRITEDATA, AVL_BYTE_EN,
    input  AVL_READDATA, AVL_READDATAVALID
  );

  modport slave (
    input  AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_WRITEDATA, AVL_BYTE_EN,
    output AVL_READDATA, AVL_READDATAVALID
  );
endinterface

// File: rtl/palette_lut.sv
// Double-buffered colour palette: host writes SHADOW, a vsync-aligned commit copies it to ACTIVE,
// pixels look up ACTIVE through a 2-stage pipe. Define PALETTE_LUT_SHADOW_EN to build SHADOW.
module palette_lut #(
  parameter  int NUM_PALETTES = 8,
  parameter  int NUM_COLORS   = 4,
  parameter  int COLOR_W      = 24,
  localparam int PAL_W        = $clog2(NUM_PALETTES),
  localparam int IDX_W        = $clog2(NUM_COLORS),
  localparam int AW           = PAL_W + IDX_W + 1
) (
  input  logic               CLK_100,
  input  logic               RESET_N,
  palette_lut_if.slave       avl,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [PAL_W-1:0]   palette,
  input  logic [IDX_W-1:0]   color_index,
  output logic [COLOR_W-1:0] rgb,
  output logic               rgb_valid,
  output logic               commit_pending
);
  localparam int N      = NUM_PALETTES * NUM_COLORS;
  localparam int STAGES = 2;

  // Reset release is registered once: accesses are taken from the second edge on.
  logic run;
  always_ff @(posedge CLK_100 or negedge RESET_N)
    if (!RESET_N) run <= 1'b0;
    else          run <= 1'b1;

  logic          acc_wr, acc_rd, sel_ctrl, ent_wr;
  logic [AW-2:0] ent;
  logic [31:0]   bmask;
  logic [COLOR_W-1:0] wmask, wdata, host_ent;

  assign sel_ctrl = avl.AVL_ADDR[AW-1];
  assign ent      = avl.AVL_ADDR[AW-2:0];
  assign acc_wr   = run & avl.AVL_CS & avl.AVL_WRITE;
  assign acc_rd   = run & avl.AVL_CS & avl.AVL_READ & ~avl.AVL_WRITE;
  assign ent_wr   = acc_wr & ~sel_ctrl;
  assign bmask    = {{8{avl.AVL_BYTE_EN[3]}}, {8{avl.AVL_BYTE_EN[2]}},
                     {8{avl.AVL_BYTE_EN[1]}}, {8{avl.AVL_BYTE_EN[0]}}};
  assign wmask    = bmask[COLOR_W-1:0];
  assign wdata    = avl.AVL_WRITEDATA[COLOR_W-1:0];

  logic [N-1:0][COLOR_W-1:0] active;

`ifdef PALETTE_LUT_SHADOW_EN
  logic [N-1:0][COLOR_W-1:0] shadow;
  logic ctrl_wr, commit;

  assign ctrl_wr  = acc_wr & sel_ctrl & (ent == '0) & avl.AVL_BYTE_EN[0] & avl.AVL_WRITEDATA[0];
  // Uses the registered pending flag, so a request arriving with frame_start waits a frame.
  assign commit   = frame_start & commit_pending;
  assign host_ent = shadow[ent];

  always_ff @(posedge CLK_100 or negedge RESET_N)
    if (!RESET_N)    shadow <= '0;
    else if (ent_wr) shadow[ent] <= (shadow[ent] & ~wmask) | (wdata & wmask);

  // Copies the pre-write SHADOW; a same-cycle host write lands in SHADOW only.
  always_ff @(posedge CLK_100 or negedge RESET_N)
    if (!RESET_N)    active <= '0;
    else if (commit) active <= shadow;

  // A new request in the commit cycle re-arms, since it may cover writes made after the copy.
  always_ff @(posedge CLK_100 or negedge RESET_N)
    if (!RESET_N)     commit_pending <= 1'b0;
    else if (ctrl_wr) commit_pending <= 1'b1;
    else if (commit)  commit_pending <= 1'b0;
`else
  assign host_ent       = active[ent];
  assign commit_pending = 1'b0;

  always_ff @(posedge CLK_100 or negedge RESET_N)
    if (!RESET_N)    active <= '0;
    else if (ent_wr) active[ent] <= (active[ent] & ~wmask) | (wdata & wmask);
`endif

  logic        unused_bits;
  assign unused_bits = ^{frame_start, avl.AVL_WRITEDATA, bmask};

  logic [31:0] rdata;
  logic        rvalid;

  always_ff @(posedge CLK_100 or negedge RESET_N)
    if (!RESET_N) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= acc_rd;
      if (acc_rd)
        rdata <= !sel_ctrl     ? 32'(host_ent) :
                 (ent == '0)   ? {30'b0, commit_pending, 1'b0} : 32'd0;
    end

  assign avl.AVL_READDATA      = rdata;
  assign avl.AVL_READDATAVALID = rvalid;

  logic [STAGES:1]  vld_pipe;
  logic [PAL_W-1:0] pal_q;
  logic [IDX_W-1:0] idx_q;

  always_ff @(posedge CLK_100 or negedge RESET_N)
    if (!RESET_N) begin
      vld_pipe <= '0;
      pal_q    <= '0;
      idx_q    <= '0;
      rgb      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], pix_valid};
      pal_q    <= palette;
      idx_q    <= color_index;
      if (vld_pipe[1]) rgb <= active[{pal_q, idx_q}];
    end

  assign rgb_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_palette_lut.sv
// Scoreboard bench for palette_lut: a table model predicts reads and lookups, monitors pop on valid.
module tb_palette_lut;
  localparam int CW = 24;
`ifdef PALETTE_LUT_SHADOW_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif

  logic        CLK_100 = 1'b0;
  logic        RESET_N = 1'b0;
  logic        frame_start = 1'b0, pix_valid = 1'b0;
  logic [2:0]  palette = '0;
  logic [1:0]  color_index = '0;
  logic [23:0] rgb;
  logic        rgb_valid, commit_pending;

  palette_lut_if #(.AW(6)) avl();

  palette_lut dut (
    .CLK_100(CLK_100), .RESET_N(RESET_N), .avl(avl),
    .frame_start(frame_start), .pix_valid(pix_valid),
    .palette(palette), .color_index(color_index),
    .rgb(rgb), .rgb_valid(rgb_valid), .commit_pending(commit_pending)
  );

  always #5 CLK_100 = ~CLK_100;

  int n_chk = 0, n_pass = 0;
  logic [31:0] rd_q[$];
  logic [31:0] rgb_q[$];
  logic [31:0] m_sh[32];
  logic [31:0] m_ac[32];
  bit          m_pend;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [5:0] ea(input int p, input int c);
    ea = {1'b0, 3'(p), 2'(c)};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin m_sh[i] = '0; m_ac[i] = '0; end
    m_pend = 1'b0;
  endtask

  // One bus cycle starting at posedge+1; model updated as the DUT will be at the next edge.
  task automatic bus(input bit rd, input bit wr, input logic [5:0] a, input logic [31:0] d,
                     input logic [3:0] be, input bit fs);
    logic [31:0] e;
    if (rd && !wr) begin
      if (a[5]) e = (a[4:0] == 0) ? {30'b0, m_pend, 1'b0} : 32'd0;
      else      e = SH ? m_sh[a[4:0]] : m_ac[a[4:0]];
      rd_q.push_back(e);
    end
    if (SH && fs && m_pend) begin
      for (int i = 0; i < 32; i++) m_ac[i] = m_sh[i];
      m_pend = 1'b0;
    end
    if (wr) begin
      if (!a[5]) begin
        e = SH ? m_sh[a[4:0]] : m_ac[a[4:0]];
        for (int b = 0; b < 4; b++)
          if (be[b] && b * 8 < CW) e[b*8 +: 8] = d[b*8 +: 8];
        if (SH) m_sh[a[4:0]] = e; else m_ac[a[4:0]] = e;
      end else if (a[4:0] == 0 && be[0] && d[0] && SH) m_pend = 1'b1;
    end
    avl.AVL_CS = rd | wr; avl.AVL_READ = rd; avl.AVL_WRITE = wr;
    avl.AVL_ADDR = a; avl.AVL_WRITEDATA = d; avl.AVL_BYTE_EN = be;
    frame_start = fs;
    @(posedge CLK_100); #1;
    avl.AVL_CS = 1'b0; avl.AVL_READ = 1'b0; avl.AVL_WRITE = 1'b0; frame_start = 1'b0;
  endtask

  task automatic pix(input bit v, input int p, input int c);
    pix_valid = v; palette = 3'(p); color_index = 2'(c);
    if (v) rgb_q.push_back(m_ac[{3'(p), 2'(c)}]);
    @(posedge CLK_100); #1;
    pix_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK_100); #1; end
  endtask

  always @(negedge CLK_100) if (RESET_N) begin
    if (avl.AVL_READDATAVALID) begin
      if (rd_q.size() == 0) chk("rd_spurious", 32'd1, 32'd0);
      else chk("rd_data", avl.AVL_READDATA, rd_q.pop_front());
    end
    if (rgb_valid) begin
      if (rgb_q.size() == 0) chk("rgb_spurious", 32'd1, 32'd0);
      else chk("rgb_data", 32'(rgb), rgb_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    avl.AVL_CS = 1'b0; avl.AVL_READ = 1'b0; avl.AVL_WRITE = 1'b0;
    avl.AVL_ADDR = '0; avl.AVL_WRITEDATA = '0; avl.AVL_BYTE_EN = '0;
    model_clear();
    #12;
    chk("rst_rvalid", 32'(avl.AVL_READDATAVALID), 0);
    chk("rst_rdata", avl.AVL_READDATA, 0);
    chk("rst_rgb_valid", 32'(rgb_valid), 0);
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_pend", 32'(commit_pending), 0);

    // Write offered on the first edge after release must be dropped.
    #10;
    RESET_N = 1'b1;
    avl.AVL_CS = 1'b1; avl.AVL_WRITE = 1'b1; avl.AVL_ADDR = ea(0, 0);
    avl.AVL_WRITEDATA = 32'h00123456; avl.AVL_BYTE_EN = 4'hF;
    @(posedge CLK_100); #1;
    avl.AVL_CS = 1'b0; avl.AVL_WRITE = 1'b0;
    bus(1, 0, ea(0, 0), 0, 0, 0);

    // Basic write / readback, byte enables, bytes beyond the colour width.
    bus(0, 1, ea(2, 1), 32'h00A1B2C3, 4'hF, 0);
    bus(1, 0, ea(2, 1), 0, 0, 0);
    bus(0, 1, ea(5, 3), 32'h00FFFFFF, 4'hF, 0);
    bus(0, 1, ea(5, 3), 32'h00000012, 4'h1, 0);
    bus(1, 0, ea(5, 3), 0, 0, 0);
    bus(0, 1, ea(5, 3), 32'hAB000000, 4'h8, 0);
    bus(0, 1, ea(5, 3), 32'h55AA3300, 4'h6, 0);
    bus(1, 0, ea(5, 3), 0, 0, 0);
    // Read+write together: write wins, no readdatavalid.
    bus(1, 1, ea(7, 0), 32'h00C0FFEE, 4'hF, 0);
    bus(1, 0, ea(7, 0), 0, 0, 0);
    bus(1, 0, 6'h21, 0, 0, 0);
    bus(0, 1, 6'h21, 32'h1, 4'hF, 0);
    chk("pend_other_off", 32'(commit_pending), 32'(m_pend));
    idle(2);

    // Lookup before and after commit.
    bus(0, 1, ea(3, 2), 32'h00123ABC, 4'hF, 0);
    idle(1);
    pix(1, 3, 2); idle(3);
    bus(0, 1, 6'h20, 32'h1, 4'h1, 0);
    chk("pend_set", 32'(commit_pending), 32'(m_pend));
    bus(1, 0, 6'h20, 0, 0, 0);
    bus(0, 0, 0, 0, 0, 1);
    chk("pend_clear", 32'(commit_pending), 32'(m_pend));
    idle(1);
    pix(1, 3, 2); idle(3);

    // CTRL write together with frame_start: commit waits for the next frame.
    bus(0, 1, ea(1, 1), 32'h00778899, 4'hF, 0);
    bus(0, 1, 6'h20, 32'h1, 4'h1, 1);
    chk("pend_same_cyc", 32'(commit_pending), 32'(m_pend));
    idle(1);
    pix(1, 1, 1); idle(3);
    // Commit with a same-cycle write: ACTIVE gets the pre-write value.
    bus(0, 1, ea(1, 1), 32'h00010203, 4'hF, 1);
    chk("pend_next_fs", 32'(commit_pending), 32'(m_pend));
    idle(1);
    pix(1, 1, 1); idle(3);
    bus(1, 0, ea(1, 1), 0, 0, 0);
    bus(0, 0, 0, 0, 0, 1);
    bus(0, 1, 6'h20, 32'h1, 4'h1, 0);
    bus(0, 0, 0, 0, 0, 1);
    idle(2);

    // Four back-to-back lookups: in order, 2-cycle latency.
    pix(1, 2, 1);
    chk("lat1", 32'(rgb_valid), 0);
    pix(1, 5, 3);
    chk("lat2", 32'(rgb_valid), 1);
    pix(1, 3, 2);
    pix(1, 1, 1);
    idle(2);
    chk("burst_end", 32'(rgb_valid), 0);
    idle(1);

    // Reset mid-read with a commit pending and a lookup in flight.
    bus(0, 1, 6'h20, 32'h1, 4'h1, 0);
    avl.AVL_CS = 1'b1; avl.AVL_READ = 1'b1; avl.AVL_ADDR = ea(2, 1);
    pix_valid = 1'b1; palette = 3'd2; color_index = 2'd1;
    @(posedge CLK_100); #1;
    avl.AVL_CS = 1'b0; avl.AVL_READ = 1'b0; pix_valid = 1'b0;
    chk("pre_rst_rvalid", 32'(avl.AVL_READDATAVALID), 1);
    RESET_N = 1'b0;
    #1;
    rd_q.delete(); rgb_q.delete(); model_clear();
    chk("mid_rst_rvalid", 32'(avl.AVL_READDATAVALID), 0);
    chk("mid_rst_pend", 32'(commit_pending), 0);
    chk("mid_rst_rgb_valid", 32'(rgb_valid), 0);
    chk("mid_rst_rgb", 32'(rgb), 0);
    #5;
    RESET_N = 1'b1;
    @(posedge CLK_100); #1;
    for (int i = 0; i < 32; i++) bus(1, 0, 6'(i), 0, 0, 0);
    bus(1, 0, 6'h20, 0, 0, 0);
    pix(1, 2, 1);
    idle(4);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("rgb_q_empty", rgb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
